// File: rtl/fpu_issue.sv
// fpu_issue: issue/retire sequencer in front of the FPU datapath.
//
// Accepts one request at a time from the core. Each accepted op is presented to the FPU
// with a one-cycle start strobe. The block then counts the fixed per-opcode latency,
// captures fpuout in the completion cycle, and returns the result with its tag. Only one
// op is ever in flight, so FPU wait stages from different ops cannot overlap.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   req_valid/req_ready request handshake; req_op/req_a/req_b/req_tag payload
//   fpucontrol, arg1,   opcode and operands to the FPU, held from accept to next accept
//   arg2
//   fpu_ready           one-cycle start strobe to the FPU
//   fpuout              FPU result, sampled only in the completion cycle
//   res_valid/res_ready result handshake; res_data/res_tag payload
//   busy                high whenever the sequencer is not idle
module fpu_issue #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [2:0]       fpucontrol,
  output logic [31:0]      arg1,
  output logic [31:0]      arg2,
  output logic             fpu_ready,
  input  logic [31:0]      fpuout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         fpucontrol_q, fpucontrol_d;
  logic [31:0]        arg1_q, arg1_d;
  logic [31:0]        arg2_q, arg2_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        res_data_q, res_data_d;
  logic               fpu_ready_q, fpu_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;

  // FPU compute latency in cycles, counted from the start-strobe cycle.
  function automatic logic [2:0] op_latency(input logic [2:0] op);
    logic [2:0] lat;
    case (op)
      3'b000, 3'b001: lat = 3'd2;  // add, sub
      3'b011:         lat = 3'd4;  // div
      3'b100:         lat = 3'd3;  // sqrt
      default:        lat = 3'd1;  // mul, abs, mov, neg
    endcase
    return lat;
  endfunction

  // Gated by rst so nothing is offered to the core while reset is held.
  assign req_ready = rst && (state_q == StIdle);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fpucontrol_d = fpucontrol_q;
    arg1_d       = arg1_q;
    arg2_d       = arg2_q;
    tag_d        = tag_q;
    res_data_d   = res_data_q;
    fpu_ready_d  = fpu_ready_q;
    res_valid_d  = res_valid_q;
    busy_d       = busy_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          fpucontrol_d = req_op;
          arg1_d       = req_a;
          arg2_d       = req_b;
          tag_d        = req_tag;
          fpu_ready_d  = 1'b1;
          busy_d       = 1'b1;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        cnt_d       = op_latency(fpucontrol_q);
        fpu_ready_d = 1'b0;
        state_d     = StWait;
      end
      StWait: begin
        // <= 1 rather than == 1 so a corrupted zero count still terminates.
        if (cnt_q <= 3'd1) begin
          res_data_d  = fpuout;
          cnt_d       = 3'd0;
          res_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      fpucontrol_q <= 3'd0;
      arg1_q       <= 32'd0;
      arg2_q       <= 32'd0;
      tag_q        <= '0;
      res_data_q   <= 32'd0;
      fpu_ready_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fpucontrol_q <= fpucontrol_d;
      arg1_q       <= arg1_d;
      arg2_q       <= arg2_d;
      tag_q        <= tag_d;
      res_data_q   <= res_data_d;
      fpu_ready_q  <= fpu_ready_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign fpucontrol = fpucontrol_q;
  assign arg1       = arg1_q;
  assign arg2       = arg2_q;
  assign fpu_ready  = fpu_ready_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_tag    = tag_q;
  assign busy       = busy_q;

endmodule
